// File: rtl/spike_rate_decoder.sv
// Spike-train receiver: counts spikes over a window of neuron update strobes and
// publishes each window count via a valid/ready register. Option: SPIKE_RATE_DECODER_EMA_EN.
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_spike,
  input  logic             i_run,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_clr_ovr,
  output logic [CNT_W-1:0] o_rate,
  output logic             o_rate_valid,
  input  logic             i_rate_ready,
  output logic             o_sat,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_tickCnt;
  logic [CNT_W-1:0] r_spikeCnt;
  logic             r_satFlag;
  logic [CNT_W-1:0] r_rate;
  logic             r_rateValid;
  logic             r_sat;
  logic             r_overrun;

  logic             w_start;
  logic             w_tick;
  logic             w_last;
  logic             w_blocked;
  logic [CNT_W-1:0] w_finalCnt;
  logic             w_finalSat;
  logic [CNT_W-1:0] w_rateNext;
  logic [WIN_W-1:0] w_lenLatch;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_run)  w_nextState = COUNT;
      COUNT:   if (!i_run) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A falling run beats a tick in the same cycle, so a tick needs run still high.
  assign w_start    = (r_state == IDLE) && i_run;
  assign w_tick     = (r_state == COUNT) && i_run && i_en;
  assign w_last     = w_tick && (r_tickCnt == (r_len - WIN_ONE));
  assign w_blocked  = i_spike && (r_spikeCnt == CNT_MAX);
  assign w_finalCnt = (i_spike && !w_blocked) ? (r_spikeCnt + CNT_W'(1)) : r_spikeCnt;
  assign w_finalSat = r_satFlag | w_blocked;
  assign w_lenLatch = (i_win_len == '0) ? WIN_ONE : i_win_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len      <= '0;
      r_tickCnt  <= '0;
      r_spikeCnt <= '0;
      r_satFlag  <= 1'b0;
    end else if (w_start || w_last) begin
      r_len      <= w_lenLatch;
      r_tickCnt  <= '0;
      r_spikeCnt <= '0;
      r_satFlag  <= 1'b0;
    end else if (w_tick) begin
      r_tickCnt  <= r_tickCnt + WIN_ONE;
      r_spikeCnt <= w_finalCnt;
      r_satFlag  <= w_finalSat;
    end
  end

`ifdef SPIKE_RATE_DECODER_EMA_EN
  // Fixed point with 2 fractional bits; survives leaving COUNT, cleared only by reset.
  logic [CNT_W+1:0]        r_ema;
  logic signed [CNT_W+2:0] w_emaDiff;
  logic [CNT_W+1:0]        w_emaNext;

  assign w_emaDiff  = $signed({1'b0, w_finalCnt, 2'b00}) - $signed({1'b0, r_ema});
  assign w_emaNext  = r_ema + (CNT_W+2)'(w_emaDiff >>> 2);
  assign w_rateNext = w_emaNext[CNT_W+1:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ema <= '0;
    else if (w_last) r_ema <= w_emaNext;
  end
`else
  assign w_rateNext = w_finalCnt;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rate      <= '0;
      r_sat       <= 1'b0;
      r_rateValid <= 1'b0;
    end else if (w_last) begin
      r_rate      <= w_rateNext;
      r_sat       <= w_finalSat;
      r_rateValid <= 1'b1;
    end else if (r_rateValid && i_rate_ready) begin
      r_rateValid <= 1'b0;
    end
  end

  // Setting overrun takes priority over a simultaneous clear request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    r_overrun <= 1'b0;
    else if (w_last && r_rateValid && !i_rate_ready) r_overrun <= 1'b1;
    else if (i_clr_ovr)                              r_overrun <= 1'b0;
  end

  assign o_rate       = r_rate;
  assign o_rate_valid = r_rateValid;
  assign o_sat        = r_sat;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed table, scenario sequences and
// random traffic against an arithmetic window-count model (EMA-aware via SPIKE_RATE_DECODER_EMA_EN).
module tb_spike_rate_decoder;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             en = 1'b0;
  logic             spike = 1'b0;
  logic             run = 1'b0;
  logic [WIN_W-1:0] winLen = '0;
  logic             clrOvr = 1'b0;
  logic             rateReady = 1'b0;
  logic [CNT_W-1:0] rate;
  logic             rateValid;
  logic             sat;
  logic             overrun;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model state: window progress in plain integers, outputs as expected values.
  bit mBusy;
  int mLen, mTicks, mSpikes;
  int mRate, mEma;
  bit mValid, mSat, mOvr;

  spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_spike(spike), .i_run(run),
    .i_win_len(winLen), .i_clr_ovr(clrOvr), .o_rate(rate), .o_rate_valid(rateValid),
    .i_rate_ready(rateReady), .o_sat(sat), .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mLen = 0; mTicks = 0; mSpikes = 0;
    mRate = 0; mEma = 0; mValid = 0; mSat = 0; mOvr = 0;
  endtask

  // One clock of the window rules, using the inputs currently driven.
  task automatic modelStep();
    bit done, oldValid, ovrSet;
    int cnt, d;
    done = 0; ovrSet = 0; cnt = 0;
    oldValid = mValid;
    if (!mBusy) begin
      if (run) begin
        mBusy = 1; mLen = (winLen == 0) ? 1 : int'(winLen); mTicks = 0; mSpikes = 0;
      end
    end else if (!run) begin
      mBusy = 0;
    end else if (en) begin
      mSpikes += int'(spike);
      mTicks++;
      if (mTicks == mLen) begin
        done = 1;
        cnt = (mSpikes > CNT_MAX) ? CNT_MAX : mSpikes;
        mSat = (mSpikes > CNT_MAX);
        mLen = (winLen == 0) ? 1 : int'(winLen); mTicks = 0; mSpikes = 0;
      end
    end
    if (done) begin
`ifdef SPIKE_RATE_DECODER_EMA_EN
      d = cnt * 4 - mEma;
      mEma += (d >= 0) ? d / 4 : -((-d + 3) / 4);
      mRate = mEma / 4;
`else
      d = 0;
      mRate = cnt;
`endif
      if (oldValid && !rateReady) ovrSet = 1;
      mValid = 1;
    end else if (oldValid && rateReady) begin
      mValid = 0;
    end
    if (ovrSet) mOvr = 1;
    else if (clrOvr) mOvr = 0;
  endtask

  task automatic compareModel();
    checkOutput("rate", 32'(rate), 32'(mRate));
    checkOutput("rate_valid", 32'(rateValid), 32'(mValid));
    checkOutput("sat", 32'(sat), 32'(mSat));
    checkOutput("overrun", 32'(overrun), 32'(mOvr));
    checkOutput("busy", 32'(busy), 32'(mBusy));
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit s, input int wl, input bit rdy, input bit clr);
    run = r; en = e; spike = s; winLen = WIN_W'(wl); rateReady = rdy; clrOvr = clr;
    modelStep();
    @(posedge clk);
    #1;
    compareModel();
  endtask

  typedef struct {
    bit run, en, spike;
    int wl;
    bit rdy, clr;
    bit expValid;
    int expRate;
    bit expOvr, expBusy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    modelReset();
    #1;
    checkOutput("reset_rate", 32'(rate), 0);
    checkOutput("reset_valid", 32'(rateValid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    #11 rstN = 1'b1;
    @(posedge clk); #1;

    // Directed table: window of 2, overrun, clear, simultaneous accept, abort.
    vecs[0]  = '{1,0,0,2,0,0, 0,0,0,1};
    vecs[1]  = '{1,1,1,2,0,0, 0,0,0,1};
    vecs[2]  = '{1,1,1,2,0,0, 1,2,0,1};
    vecs[3]  = '{1,1,0,7,0,0, 1,2,0,1};
    vecs[4]  = '{1,1,1,2,0,0, 1,1,1,1};
    vecs[5]  = '{1,0,0,2,0,1, 1,1,0,1};
    vecs[6]  = '{1,1,0,2,0,0, 1,1,0,1};
    vecs[7]  = '{1,1,0,2,1,0, 1,0,0,1};
    vecs[8]  = '{1,0,0,2,1,0, 0,0,0,1};
    vecs[9]  = '{0,1,1,2,1,0, 0,0,0,0};
    vecs[10] = '{0,1,0,2,1,0, 0,0,0,0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].run, vecs[i].en, vecs[i].spike, vecs[i].wl, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(rateValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].expOvr));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
`ifndef SPIKE_RATE_DECODER_EMA_EN
      checkOutput($sformatf("vec%0d_rate", i), 32'(rate), 32'(vecs[i].expRate));
`endif
    end

    // Basic count: 10 strobes, one every 4th clock, spikes on strobes 0, 4 and 7.
    applyStimulus(1, 0, 0, 10, 1, 0);
    for (int i = 0; i < 40; i++) begin
      bit e;
      int k;
      e = (i % 4 == 3);
      k = i / 4;
      applyStimulus(1, e, e && (k == 0 || k == 4 || k == 7), 10, 1, 0);
      if (i == 35) checkOutput("basic_not_early", 32'(rateValid), 0);
    end
    checkOutput("basic_valid", 32'(rateValid), 1);
    checkOutput("basic_sat", 32'(sat), 0);
`ifndef SPIKE_RATE_DECODER_EMA_EN
    checkOutput("basic_rate", 32'(rate), 3);
`endif
    applyStimulus(0, 0, 0, 10, 1, 0);

    // Saturation over 300 strobes, then a short window of 5 spikes.
    applyStimulus(1, 0, 0, 300, 1, 0);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 1, (i == 299) ? 5 : 300, 1, 0);
    checkOutput("sat_flag", 32'(sat), 1);
`ifndef SPIKE_RATE_DECODER_EMA_EN
    checkOutput("sat_rate", 32'(rate), CNT_MAX);
`endif
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 5, 1, 0);
    checkOutput("post_sat_flag", 32'(sat), 0);
`ifndef SPIKE_RATE_DECODER_EMA_EN
    checkOutput("post_sat_rate", 32'(rate), 5);
`endif
    applyStimulus(0, 0, 0, 5, 1, 0);
    applyStimulus(0, 0, 0, 5, 1, 0);

    // Abort after 2 of 8 strobes.
    applyStimulus(1, 0, 0, 8, 1, 0);
    applyStimulus(1, 1, 1, 8, 1, 0);
    applyStimulus(1, 1, 1, 8, 1, 0);
    applyStimulus(0, 1, 1, 8, 1, 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_valid", 32'(rateValid), 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 8, 1, 0);
    checkOutput("abort_valid_later", 32'(rateValid), 0);

    // Zero length: every strobe completes its own window.
    applyStimulus(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, i[0], 0, 1, 0);
      checkOutput("len0_valid", 32'(rateValid), 1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-window while rate_valid is high.
    applyStimulus(1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 3, 0, 0);
    checkOutput("pre_reset_valid", 32'(rateValid), 1);
    #1 rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rate", 32'(rate), 0);
    checkOutput("async_valid", 32'(rateValid), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_sat", 32'(sat), 0);
    checkOutput("async_overrun", 32'(overrun), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    applyStimulus(1, 0, 0, 3, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, (i == 1), 3, 1, 0);
    checkOutput("after_reset_valid", 32'(rateValid), 1);
`ifndef SPIKE_RATE_DECODER_EMA_EN
    checkOutput("after_reset_rate", 32'(rate), 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 64) != 0, $urandom % 2, $urandom % 2,
                    int'($urandom_range(0, 6)), $urandom % 2, ($urandom % 8) == 0);
    end

    // Smoothing: constant count of 8 per window starting from a fresh ema.
    rstN = 1'b0;
    #1 modelReset();
    @(posedge clk); #1;
    rstN = 1'b1;
    applyStimulus(1, 0, 0, 8, 1, 0);
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 8, 1, 0);
`ifdef SPIKE_RATE_DECODER_EMA_EN
      if (w == 0) checkOutput("ema_first", 32'(rate), 2);
      if (w == 1) checkOutput("ema_second", 32'(rate), 3);
`else
      checkOutput("raw_window", 32'(rate), 8);
`endif
    end
    applyStimulus(0, 0, 0, 8, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
